// File: rtl/pe_boot_ctrl.sv
// rtl/pe_boot_ctrl.sv - per-PE configuration and boot sequencer
//
// Purpose: accepts host LOAD/START/STOP/NOP commands over a valid/ready
// handshake. It drives each PE's conf_en/start_en pair and forwards
// instruction-memory writes to the selected PE. It also tracks the shared
// reset-release delay, so pe_running rises RST_LAT cycles after start_en.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op                     0=NOP 1=LOAD 2=START 3=STOP
//   cmd_pe/cmd_addr/cmd_data   target PE, LOAD address and LOAD word
//   conf_en/start_en           per-PE enables
//   imem_wren/pe/addr/wdata    one-cycle instruction-memory write
//   pe_running                 per-PE running status
//   err_pulse                  one-cycle illegal-command pulse
module pe_boot_ctrl #(
   parameter int PE_NUM  = 4,
   parameter int PE_W    = 2,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int RST_LAT = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [PE_W-1:0]   cmd_pe,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [PE_NUM-1:0] conf_en,
   output logic [PE_NUM-1:0] start_en,
   output logic              imem_wren,
   output logic [PE_W-1:0]   imem_pe,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic [PE_NUM-1:0] pe_running,
   output logic              err_pulse
);

   // Encoding is {conf_en, start_en, pe_running}, so every per-PE output
   // is a bit of the state flop rather than a decode of it.
   typedef enum logic [2:0] {
      IDLE = 3'b000,
      CONF = 3'b100,
      BOOT = 3'b010,
      RUN  = 3'b011
   } pe_state_t;

   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_START = 2'd2;
   localparam logic [1:0] OP_STOP  = 2'd3;

   pe_state_t         state_q [PE_NUM];
   pe_state_t         state_d [PE_NUM];
   logic [3:0]        cnt_q, cnt_d;
   logic [PE_W-1:0]   boot_pe_q, boot_pe_d;
   logic              ready_q, ready_d;
   logic              err_d, wren_d;
   logic              accept, pe_ok, set_tgt;
   pe_state_t         tgt_state, new_state;

   assign accept = cmd_valid & ready_q;

   always_comb begin
      for (int i = 0; i < PE_NUM; i++) state_d[i] = state_q[i];
      cnt_d     = cnt_q;
      boot_pe_d = boot_pe_q;
      ready_d   = 1'b1;
      err_d     = 1'b0;
      wren_d    = 1'b0;
      set_tgt   = 1'b0;
      new_state = IDLE;
      tgt_state = IDLE;
      pe_ok     = 1'b0;

      for (int i = 0; i < PE_NUM; i++) begin
         if (cmd_pe == PE_W'(i)) begin
            tgt_state = state_q[i];
            pe_ok     = 1'b1;
         end
      end

      // Boot countdown. Keep cmd_ready low until the edge where the PE
      // enters RUN, so it returns high in the same cycle as pe_running.
      if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            for (int i = 0; i < PE_NUM; i++)
               if (boot_pe_q == PE_W'(i)) state_d[i] = RUN;
         end else begin
            ready_d = 1'b0;
         end
      end

      // A command is only accepted while cmd_ready is high. At those times
      // no boot is in progress, so this block cannot conflict with the
      // countdown above.
      if (accept) begin
         unique case (cmd_op)
            OP_LOAD: begin
               if (!pe_ok || tgt_state == RUN) begin
                  err_d = 1'b1;
               end else begin
                  wren_d    = 1'b1;
                  set_tgt   = 1'b1;
                  new_state = CONF;
               end
            end
            OP_START: begin
               if (!pe_ok || tgt_state == RUN) begin
                  err_d = 1'b1;
               end else begin
                  set_tgt   = 1'b1;
                  new_state = BOOT;
                  cnt_d     = 4'(RST_LAT);
                  boot_pe_d = cmd_pe;
                  ready_d   = 1'b0;
               end
            end
            OP_STOP: begin
               if (!pe_ok) begin
                  err_d = 1'b1;
               end else begin
                  set_tgt   = 1'b1;
                  new_state = IDLE;
               end
            end
            default: ;
         endcase
      end

      if (set_tgt) begin
         for (int i = 0; i < PE_NUM; i++)
            if (cmd_pe == PE_W'(i)) state_d[i] = new_state;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < PE_NUM; i++) state_q[i] <= IDLE;
         cnt_q      <= '0;
         boot_pe_q  <= '0;
         ready_q    <= 1'b0;
         err_pulse  <= 1'b0;
         imem_wren  <= 1'b0;
         imem_pe    <= '0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         for (int i = 0; i < PE_NUM; i++) state_q[i] <= state_d[i];
         cnt_q     <= cnt_d;
         boot_pe_q <= boot_pe_d;
         ready_q   <= ready_d;
         err_pulse <= err_d;
         imem_wren <= wren_d;
         if (wren_d) begin
            imem_pe    <= cmd_pe;
            imem_addr  <= cmd_addr;
            imem_wdata <= cmd_data;
         end
      end
   end

   assign cmd_ready = ready_q;

   always_comb begin
      for (int i = 0; i < PE_NUM; i++) begin
         conf_en[i]    = state_q[i][2];
         start_en[i]   = state_q[i][1];
         pe_running[i] = state_q[i][0];
      end
   end

   a_conf_start_excl: assert property (@(posedge clk) disable iff (!rstn)
      (conf_en & start_en) == '0);

endmodule

// File: tb/tb_pe_boot_ctrl.sv
// tb/tb_pe_boot_ctrl.sv - scoreboard testbench for pe_boot_ctrl
module tb_pe_boot_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [1:0]  cmd_pe = 2'd0;
   logic [9:0]  cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic [3:0]  conf_en, start_en, pe_running;
   logic        imem_wren, err_pulse;
   logic [1:0]  imem_pe;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        is_err;
      logic [1:0]  pe;
      logic [9:0]  addr;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   pe_boot_ctrl #(.PE_NUM(4), .PE_W(2), .ADDR_W(10), .DATA_W(32), .RST_LAT(3)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_pe(cmd_pe), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .conf_en(conf_en), .start_en(start_en),
      .imem_wren(imem_wren), .imem_pe(imem_pe), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .pe_running(pe_running), .err_pulse(err_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // kind: 0 = no response, 1 = write strobe, 2 = error pulse
   task automatic send(input logic [1:0] op, input logic [1:0] pe,
                       input logic [9:0] addr, input logic [31:0] data, input int kind);
      int n = 0;
      exp_t e;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
      if (kind != 0) begin
         e.is_err = (kind == 2);
         e.pe = pe; e.addr = addr; e.data = data;
         exp_q.push_back(e);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_pe = pe; cmd_addr = addr; cmd_data = data;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 2'd0;
   endtask

   task automatic pe_chk(input string name, input logic [3:0] c, input logic [3:0] s,
                         input logic [3:0] r);
      chk({name, "_conf"}, 64'(conf_en), 64'(c));
      chk({name, "_start"}, 64'(start_en), 64'(s));
      chk({name, "_run"}, 64'(pe_running), 64'(r));
   endtask

   function automatic logic [63:0] all_out();
      return 64'({cmd_ready, conf_en, start_en, imem_wren, imem_pe, imem_addr,
                  imem_wdata, pe_running, err_pulse});
   endfunction

   // Monitor: every write strobe or error pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && (imem_wren || err_pulse)) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected", 64'({imem_wren, err_pulse}), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_kind", 64'({imem_wren, err_pulse}), 64'({!e.is_err, e.is_err}));
               if (!e.is_err) begin
                  chk("sb_pe", 64'(imem_pe), 64'(e.pe));
                  chk("sb_addr", 64'(imem_addr), 64'(e.addr));
                  chk("sb_data", 64'(imem_wdata), 64'(e.data));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset release
      repeat (2) @(posedge clk);
      #1 chk("reset_all_zero", all_out(), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      #1 chk("ready_before_edge", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
      chk("ready_after_release", 64'(cmd_ready), 64'd1);
      pe_chk("post_reset", 4'b0000, 4'b0000, 4'b0000);

      // 2: back-to-back LOADs to PE2, plus a boundary-value LOAD to PE0
      send(2'd1, 2'd2, 10'h010, 32'hDEADBEEF, 1);
      pe_chk("load1", 4'b0100, 4'b0000, 4'b0000);
      send(2'd1, 2'd2, 10'h011, 32'h12345678, 1);
      chk("load2_wren", 64'(imem_wren), 64'd1);
      send(2'd1, 2'd0, 10'h3FF, 32'hFFFFFFFF, 1);
      pe_chk("load3", 4'b0101, 4'b0000, 4'b0000);
      send(2'd0, 2'd3, 10'h000, 32'h0, 0);
      pe_chk("nop", 4'b0101, 4'b0000, 4'b0000);

      // 3: START PE2, RST_LAT = 3
      send(2'd2, 2'd2, 10'h0, 32'h0, 0);
      pe_chk("start_t1", 4'b0001, 4'b0100, 4'b0000);
      chk("ready_t1", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1 chk("ready_t2", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1 chk("ready_t3", 64'(cmd_ready), 64'd0);
      chk("run_t3", 64'(pe_running), 64'd0);
      @(posedge clk); #1 chk("ready_t4", 64'(cmd_ready), 64'd1);
      pe_chk("run_t4", 4'b0001, 4'b0100, 4'b0100);

      // 4: LOAD / START to a running PE are errors
      send(2'd1, 2'd2, 10'h020, 32'hCAFEF00D, 2);
      send(2'd2, 2'd2, 10'h0, 32'h0, 2);
      pe_chk("err_hold", 4'b0001, 4'b0100, 4'b0100);

      // 5: STOP running PE2, STOP idle PE1
      send(2'd3, 2'd2, 10'h0, 32'h0, 0);
      pe_chk("stop_pe2", 4'b0001, 4'b0000, 4'b0000);
      send(2'd3, 2'd1, 10'h0, 32'h0, 0);
      pe_chk("stop_pe1", 4'b0001, 4'b0000, 4'b0000);
      chk("stop_idle_err", 64'(err_pulse), 64'd0);

      // 6: reset in the middle of PE0's boot
      send(2'd2, 2'd0, 10'h0, 32'h0, 0);
      pe_chk("start_pe0", 4'b0000, 4'b0001, 4'b0000);
      @(posedge clk); #1 rstn = 1'b0;
      #1 chk("midboot_reset_zero", all_out(), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      chk("rerelease_ready", 64'(cmd_ready), 64'd1);
      pe_chk("rerelease", 4'b0000, 4'b0000, 4'b0000);
      repeat (5) @(posedge clk); #1;
      chk("pe0_stays_idle", 64'(pe_running), 64'd0);

      repeat (2) @(posedge clk);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
